// File: rtl/imm_pkg.sv
// Shared definitions for the immediate generator: format selects, skid states, XLEN check.
package imm_pkg;

  localparam logic [2:0] IMM_I   = 3'b000;
  localparam logic [2:0] IMM_S   = 3'b001;
  localparam logic [2:0] IMM_B   = 3'b010;
  localparam logic [2:0] IMM_J   = 3'b011;
  localparam logic [2:0] IMM_U   = 3'b100;
  localparam logic [2:0] IMM_Z   = 3'b101;
  localparam logic [2:0] IMM_SH  = 3'b110;
  localparam logic [2:0] IMM_RSV = 3'b111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  function automatic bit xlen_legal(input int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction for all RV formats, sign/zero-extended to XLEN.
// No state, no handshake; shared with the single-cycle core.
import imm_pkg::*;

module imm_decode #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_src,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  // The opcode field never contributes to an immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (imm_src)
      IMM_I:  imm = XLEN'($signed(instr[31:20]));
      IMM_S:  imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      IMM_B:  imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMM_J:  imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      IMM_U:  imm = XLEN'($signed({instr[31:12], 12'b0}));
      IMM_Z:  imm = XLEN'(instr[19:15]);
      IMM_SH: begin
        // RV64 shifts take a 6-bit shamt; bit 25 belongs to funct7 on RV32.
        if (XLEN == 64) imm = XLEN'(instr[25:20]);
        else            imm = XLEN'(instr[24:20]);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with PC-relative target; 1-cycle latency, 1 beat/cycle.
// Output register plus one skid entry; in_ready is registered and drops only when both are full.
import imm_pkg::*;

module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [2:0]      in_imm_src,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic            illegal;
  } beat_t;

  skid_state_e state_q, state_d;
  beat_t       out_q, out_d;
  beat_t       skid_q, skid_d;
  beat_t       new_beat;
  logic        in_ready_q, in_ready_d;
  logic        accept, drain;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .imm_src (in_imm_src),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  // Reserved selects decode to imm=0, so the target collapses to the PC.
  always_comb begin
    new_beat.imm     = dec_imm;
    new_beat.target  = in_pc + dec_imm;
    new_beat.illegal = dec_illegal;
  end

  assign out_valid   = (state_q != ST_EMPTY);
  assign in_ready    = in_ready_q;
  assign out_imm     = out_q.imm;
  assign out_target  = out_q.target;
  assign out_illegal = out_q.illegal;

  assign accept = in_valid && in_ready_q && !flush;
  assign drain  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          out_d   = new_beat;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          out_d = new_beat;
        end else if (accept) begin
          state_d = ST_FULL;
          skid_d  = new_beat;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (drain) begin
          state_d = ST_ONE;
          out_d   = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush discards everything; a beat draining this cycle has already left.
    if (flush) state_d = ST_EMPTY;
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed plus randomized checks of imm_gen_pipe (XLEN=32 and XLEN=64) against a queue-based model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_pc, out_imm, out_target;
  logic [2:0]  in_imm_src;

  logic        flush_w, in_valid_w, in_ready_w, out_valid_w, out_ready_w, out_illegal_w;
  logic [31:0] in_instr_w;
  logic [2:0]  in_imm_src_w;
  logic [63:0] in_pc_w, out_imm_w, out_target_w;

  int n_tests = 0;
  int n_fail  = 0;
  int n_drained = 0;

  typedef struct {
    logic [31:0] imm;
    logic [31:0] target;
    logic        illegal;
  } beat_t;
  beat_t q[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_imm_src(in_imm_src), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_target(out_target), .out_illegal(out_illegal)
  );

  imm_gen_pipe #(.XLEN(64)) dut_w (
    .clk(clk), .rst_n(rst_n), .flush(flush_w),
    .in_valid(in_valid_w), .in_ready(in_ready_w), .in_instr(in_instr_w),
    .in_imm_src(in_imm_src_w), .in_pc(in_pc_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .out_imm(out_imm_w),
    .out_target(out_target_w), .out_illegal(out_illegal_w)
  );

  function automatic longint sext(input longint v, input int bits);
    longint m;
    m = (longint'(1) << bits) - 1;
    v = v & m;
    if (v[bits-1]) return v - (longint'(1) << bits);
    return v;
  endfunction

  // Reference immediate from the format field layouts, built with shifts and masks.
  function automatic logic [63:0] ref_imm(input logic [31:0] instr, input logic [2:0] src, input int xlen);
    longint x, v;
    x = longint'({32'b0, instr});
    case (src)
      3'd0: v = sext(x >> 20, 12);
      3'd1: v = sext((((x >> 25) & 127) << 5) | ((x >> 7) & 31), 12);
      3'd2: v = sext((((x >> 31) & 1) << 12) | (((x >> 7) & 1) << 11)
                   | (((x >> 25) & 63) << 5) | (((x >> 8) & 15) << 1), 13);
      3'd3: v = sext((((x >> 31) & 1) << 20) | (((x >> 12) & 255) << 12)
                   | (((x >> 20) & 1) << 11) | (((x >> 21) & 1023) << 1), 21);
      3'd4: v = sext(x & 64'hFFFF_F000, 32);
      3'd5: v = (x >> 15) & 31;
      3'd6: v = (x >> 20) & ((xlen == 64) ? 63 : 31);
      default: v = 0;
    endcase
    if (xlen == 32) return {32'b0, v[31:0]};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of the 32-bit DUT: compare against the model at negedge, then update the model.
  task automatic cycle();
    beat_t b;
    logic  acc, drn;
    @(negedge clk);
    chk("out_valid", {63'b0, out_valid}, {63'b0, q.size() > 0});
    chk("in_ready", {63'b0, in_ready}, {63'b0, q.size() < 2});
    if (q.size() > 0) begin
      chk("out_imm", {32'b0, out_imm}, {32'b0, q[0].imm});
      chk("out_target", {32'b0, out_target}, {32'b0, q[0].target});
      chk("out_illegal", {63'b0, out_illegal}, {63'b0, q[0].illegal});
    end
    b.imm     = ref_imm(in_instr, in_imm_src, 32);
    b.target  = in_pc + b.imm;
    b.illegal = (in_imm_src == 3'd7);
    acc = in_valid && (q.size() < 2) && !flush;
    drn = (q.size() > 0) && out_ready;
    if (drn) begin
      void'(q.pop_front());
      n_drained++;
    end
    if (flush) q.delete();
    else if (acc) q.push_back(b);
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] instr, input logic [2:0] src, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = instr; in_imm_src = src; in_pc = pc;
  endtask

  task automatic step_w();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] e;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_imm_src = '0; in_pc = '0;
    flush_w = 1'b0; in_valid_w = 1'b0; out_ready_w = 1'b1;
    in_instr_w = '0; in_imm_src_w = '0; in_pc_w = '0;
    #12;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_out_imm", {32'b0, out_imm}, 64'd0);
    chk("rst_out_target", {32'b0, out_target}, 64'd0);
    chk("rst_out_illegal", {63'b0, out_illegal}, 64'd0);
    chk("rst_w_out_valid", {63'b0, out_valid_w}, 64'd0);
    chk("rst_w_in_ready", {63'b0, in_ready_w}, 64'd1);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed formats from the test plan.
    put(32'hFFF00093, 3'b000, 32'h100); cycle(); in_valid = 1'b0;
    chk("i_imm", {32'b0, out_imm}, 64'hFFFF_FFFF);
    chk("i_target", {32'b0, out_target}, 64'h0000_00FF);
    put(32'hFE000EE3, 3'b010, 32'h200); cycle(); in_valid = 1'b0;
    chk("b_imm", {32'b0, out_imm}, 64'hFFFF_FFFC);
    chk("b_target", {32'b0, out_target}, 64'h0000_01FC);
    put(32'h0010006F, 3'b011, 32'h0); cycle(); in_valid = 1'b0;
    chk("j_imm", {32'b0, out_imm}, 64'h0000_0800);
    chk("j_target", {32'b0, out_target}, 64'h0000_0800);
    put(32'h1234_5678, 3'b111, 32'hABC0); cycle(); in_valid = 1'b0;
    chk("rsv_illegal", {63'b0, out_illegal}, 64'd1);
    chk("rsv_target", {32'b0, out_target}, 64'hABC0);
    cycle(); cycle();

    // Backpressure: A, B, C with the consumer stalled.
    n_drained = 0;
    out_ready = 1'b0;
    put(32'h0010_0093, 3'b000, 32'h10); cycle();
    put(32'h0020_0093, 3'b000, 32'h20); cycle();
    chk("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
    put(32'h0030_0093, 3'b000, 32'h30); cycle(); cycle(); cycle();
    chk("bp_hold_imm", {32'b0, out_imm}, 64'd1);
    out_ready = 1'b1;
    cycle(); cycle(); in_valid = 1'b0; cycle(); cycle();
    chk("bp_drained", n_drained, 64'd3);
    chk("bp_empty", {63'b0, out_valid}, 64'd0);

    // Flush while full, with a beat offered.
    out_ready = 1'b0;
    put(32'h0040_0093, 3'b000, 32'h0); cycle();
    put(32'h0050_0093, 3'b000, 32'h0); cycle();
    put(32'h0060_0093, 3'b000, 32'h0); flush = 1'b1; cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", {63'b0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'b0, in_ready}, 64'd1);
    out_ready = 1'b1; cycle();
    // Flush wins over an accept in the empty state.
    put(32'h0070_0093, 3'b000, 32'h0); flush = 1'b1; cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_drop", {63'b0, out_valid}, 64'd0);

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    put(32'h0080_0093, 3'b000, 32'h0); cycle();
    put(32'h0090_0093, 3'b000, 32'h0); cycle();
    in_valid = 1'b0;
    rst_n = 1'b0; #1;
    chk("arst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("arst_in_ready", {63'b0, in_ready}, 64'd1);
    q.delete();
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    cycle(); cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 31) == 0);
      in_instr   = $urandom;
      in_imm_src = 3'($urandom_range(0, 7));
      in_pc      = $urandom;
      cycle();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    cycle(); cycle();

    // XLEN=64 instance.
    in_valid_w = 1'b1; in_instr_w = 32'h800002B7; in_imm_src_w = 3'b100; in_pc_w = 64'h1000;
    step_w(); in_valid_w = 1'b0;
    chk("w_u_valid", {63'b0, out_valid_w}, 64'd1);
    chk("w_u_imm", out_imm_w, 64'hFFFF_FFFF_8000_0000);
    chk("w_u_target", out_target_w, 64'hFFFF_FFFF_8000_1000);
    in_valid_w = 1'b1; in_instr_w = 32'hDEAD_BEEF; in_imm_src_w = 3'b111; in_pc_w = 64'h1234_5678_9ABC;
    step_w(); in_valid_w = 1'b0;
    chk("w_rsv_illegal", {63'b0, out_illegal_w}, 64'd1);
    chk("w_rsv_imm", out_imm_w, 64'd0);
    chk("w_rsv_target", out_target_w, 64'h1234_5678_9ABC);
    in_valid_w = 1'b1; in_instr_w = 32'h02A0_0013; in_imm_src_w = 3'b110; in_pc_w = 64'h0;
    step_w(); in_valid_w = 1'b0;
    chk("w_shamt6", out_imm_w, 64'd42);
    for (int i = 0; i < 60; i++) begin
      in_valid_w   = 1'b1;
      in_instr_w   = $urandom;
      in_imm_src_w = 3'($urandom_range(0, 7));
      in_pc_w      = {$urandom, $urandom};
      step_w();
      in_valid_w = 1'b0;
      e = ref_imm(in_instr_w, in_imm_src_w, 64);
      chk("w_rand_valid", {63'b0, out_valid_w}, 64'd1);
      chk("w_rand_imm", out_imm_w, e);
      chk("w_rand_target", out_target_w, in_pc_w + e);
      chk("w_rand_illegal", {63'b0, out_illegal_w}, {63'b0, in_imm_src_w == 3'd7});
    end
    step_w();
    chk("w_idle", {63'b0, out_valid_w}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
